// File: rtl/jpeg_bitstream_framer.sv
// JPEG bitstream framer: buffers encoder words in a FIFO and re-emits each frame as
// MAGIC + dimensions header, payload words, and a size/status trailer on a ready/valid stream.
module jpeg_bitstream_framer #(
  parameter int unsigned DEPTH = 512,
  parameter logic [31:0] MAGIC = 32'h4A504547
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] enc_pixel_x,
  input  logic [11:0] enc_pixel_y,
  input  logic [31:0] enc_data,
  input  logic        enc_data_valid,
  input  logic        enc_eof_valid,
  input  logic [4:0]  enc_eof_bits,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count,
  output logic        overflow_sticky,
  input  logic        clr_stats
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic        err;
    logic [4:0]  bits;
    logic [11:0] x;
    logic [11:0] y;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [2:0] {RD_IDLE, RD_HDR0, RD_HDR1, RD_PAY, RD_TRL} rd_state_e;

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, fill;
  logic        fifo_empty, fifo_full;
  entry_t      head;

  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == (AW+1)'(DEPTH));
  assign head       = mem[rd_ptr_q[AW-1:0]];

  // ---------------------------------------------------------------- write side
  logic        in_frame_q, in_frame_d;
  logic        drop_q, drop_d;
  logic        term_q, term_d;
  logic        push, ovf_set;
  entry_t      push_entry;
  logic [1:0]  n_in, drop_inc;
  logic [16:0] drop_sum;
  logic [15:0] drop_count_q, drop_count_d;
  logic        ovf_q;

  assign n_in = {1'b0, enc_data_valid} + {1'b0, enc_eof_valid};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    push       = 1'b0;
    ovf_set    = 1'b0;
    drop_inc   = 2'd0;
    in_frame_d = in_frame_q;
    drop_d     = drop_q;
    term_d     = term_q;
    push_entry = '{sof: !in_frame_q, eof: 1'b0, err: 1'b0, bits: 5'd0,
                   x: enc_pixel_x, y: enc_pixel_y, data: enc_data};
    if (term_q) begin
      // A pending terminator blocks all input, including the start of a new frame.
      drop_inc = n_in;
      if (!fifo_full) begin
        push       = 1'b1;
        push_entry = '0;
        push_entry.eof = 1'b1;
        push_entry.err = 1'b1;
        term_d     = 1'b0;
      end
    end else if (drop_q) begin
      drop_inc = {1'b0, enc_data_valid};
      if (enc_eof_valid) begin
        drop_d     = 1'b0;
        term_d     = 1'b1;
        in_frame_d = 1'b0;
      end
    end else if (enc_eof_valid) begin
      in_frame_d = 1'b0;
      if (fifo_full) begin
        drop_inc = n_in;
        ovf_set  = 1'b1;
        term_d   = 1'b1;
      end else begin
        push            = 1'b1;
        push_entry.eof  = 1'b1;
        push_entry.bits = enc_eof_bits;
        drop_inc        = {1'b0, enc_data_valid};
      end
    end else if (enc_data_valid) begin
      in_frame_d = 1'b1;
      if (fifo_full) begin
        drop_inc = 2'd1;
        ovf_set  = 1'b1;
        drop_d   = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  assign drop_sum     = {1'b0, drop_count_q} + 17'(drop_inc);
  assign drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      in_frame_q   <= 1'b0;
      drop_q       <= 1'b0;
      term_q       <= 1'b0;
      drop_count_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      in_frame_q <= in_frame_d;
      drop_q     <= drop_d;
      term_q     <= term_d;
      if (clr_stats) begin
        drop_count_q <= '0;
        ovf_q        <= 1'b0;
      end else begin
        drop_count_q <= drop_count_d;
        if (ovf_set) ovf_q <= 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  // ----------------------------------------------------------------- read side
  rd_state_e   rd_state_q;
  logic [31:0] m_data_q;
  logic        m_valid_q, m_last_q;
  logic [23:0] wcnt_q;
  logic [4:0]  bits_q;
  logic        err_q, eof_seen_q;
  logic [15:0] frame_count_q;
  logic        fetch;

  // The output register holds the current beat; a payload/trailer fetch fills it once it frees.
  assign fetch = (rd_state_q == RD_PAY || rd_state_q == RD_HDR1) && (!m_valid_q || m_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_q    <= RD_IDLE;
      rd_ptr_q      <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      wcnt_q        <= '0;
      bits_q        <= '0;
      err_q         <= 1'b0;
      eof_seen_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: if (!fifo_empty) begin
          if (head.sof) begin
            m_data_q   <= MAGIC;
            m_valid_q  <= 1'b1;
            m_last_q   <= 1'b0;
            rd_state_q <= RD_HDR0;
          end else begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
          end
        end
        RD_HDR0: if (m_ready) begin
          m_data_q   <= {8'h00, head.y, head.x};
          rd_state_q <= RD_HDR1;
        end
        RD_HDR1: if (m_ready) rd_state_q <= RD_PAY;
        RD_TRL: if (m_ready) begin
          m_valid_q  <= 1'b0;
          m_last_q   <= 1'b0;
          wcnt_q     <= '0;
          bits_q     <= '0;
          err_q      <= 1'b0;
          eof_seen_q <= 1'b0;
          rd_state_q <= RD_IDLE;
        end
        default: ;
      endcase

      if (fetch) begin
        if (eof_seen_q) begin
          m_data_q   <= {1'b0, 2'b00, bits_q, wcnt_q};
          m_valid_q  <= 1'b1;
          m_last_q   <= 1'b1;
          rd_state_q <= RD_TRL;
        end else if (!fifo_empty && head.err) begin
          rd_ptr_q   <= rd_ptr_q + (AW+1)'(1);
          err_q      <= 1'b1;
          m_data_q   <= {1'b1, 2'b00, bits_q, wcnt_q};
          m_valid_q  <= 1'b1;
          m_last_q   <= 1'b1;
          rd_state_q <= RD_TRL;
        end else if (!fifo_empty) begin
          rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
          wcnt_q    <= wcnt_q + 24'd1;
          m_data_q  <= head.data;
          m_valid_q <= 1'b1;
          m_last_q  <= 1'b0;
          if (head.eof) begin
            bits_q     <= head.bits;
            eof_seen_q <= 1'b1;
          end
        end else begin
          m_valid_q <= 1'b0;
        end
      end

      if (clr_stats) frame_count_q <= '0;
      else if (rd_state_q == RD_TRL && m_ready && !err_q) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign m_data          = m_data_q;
  assign m_valid         = m_valid_q;
  assign m_last          = m_last_q;
  assign frame_count     = frame_count_q;
  assign drop_count      = drop_count_q;
  assign overflow_sticky = ovf_q;
  assign busy            = in_frame_q | drop_q | term_q | (rd_state_q != RD_IDLE) | !fifo_empty;

endmodule

// File: tb/tb_jpeg_bitstream_framer.sv
// Self-checking bench for jpeg_bitstream_framer: expected beats go into a scoreboard queue as
// stimulus is driven and are compared as the DUT hands them over.
`timescale 1ns/1ps
module tb_jpeg_bitstream_framer;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] MAGIC = 32'h4A504547;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] enc_pixel_x = '0, enc_pixel_y = '0;
  logic [31:0] enc_data = '0;
  logic        enc_data_valid = 1'b0, enc_eof_valid = 1'b0;
  logic [4:0]  enc_eof_bits = '0;
  logic [31:0] m_data;
  logic        m_valid, m_last, busy, overflow_sticky;
  logic        m_ready = 1'b1;
  logic [15:0] frame_count, drop_count;
  logic        clr_stats = 1'b0;

  always #5 clk = ~clk;

  jpeg_bitstream_framer #(.DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
    .clk(clk), .rstn(rstn),
    .enc_pixel_x(enc_pixel_x), .enc_pixel_y(enc_pixel_y),
    .enc_data(enc_data), .enc_data_valid(enc_data_valid),
    .enc_eof_valid(enc_eof_valid), .enc_eof_bits(enc_eof_bits),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .frame_count(frame_count), .drop_count(drop_count),
    .overflow_sticky(overflow_sticky), .clr_stats(clr_stats)
  );

  typedef struct packed { logic last; logic [31:0] data; } beat_t;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    int          n_data;
    logic [4:0]  bits;
    int          rmode;     // 0: ready high, 1: toggling, 2: ready low
    logic [31:0] exp_dims;
    logic [31:0] exp_trl;
  } frame_vec_t;

  beat_t      sb_q[$];
  frame_vec_t vecs[3];
  int         total = 0;
  int         bad = 0;
  int         rmode = 0;
  int         exp_frames = 0;
  logic       stall_q = 1'b0;
  beat_t      stall_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // Sink ready pattern, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: consumes accepted beats and checks that stalled beats are held.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_beat", {m_last, m_data}, stall_beat);
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_beat: got %h, wanted no beat", {m_last, m_data});
        end else begin
          check("beat", {m_last, m_data}, sb_q.pop_front());
        end
      end
      stall_q    <= m_valid && !m_ready;
      stall_beat <= {m_last, m_data};
    end
  end

  task automatic drive(input logic dv, input logic ev, input logic [31:0] d, input logic [4:0] b,
                       input logic [11:0] x, input logic [11:0] y);
    @(posedge clk); #1;
    enc_data_valid = dv;
    enc_eof_valid  = ev;
    enc_data       = d;
    enc_eof_bits   = b;
    enc_pixel_x    = x;
    enc_pixel_y    = y;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic send_frame(input logic [11:0] x, input logic [11:0] y, input int n,
                            input logic [4:0] b, input logic [31:0] dims, input logic [31:0] trl);
    logic [31:0] w;
    sb_q.push_back({1'b0, MAGIC});
    sb_q.push_back({1'b0, dims});
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      drive(1'b1, 1'b0, w, '0, x, y);
      sb_q.push_back({1'b0, w});
    end
    w = $urandom;
    drive(1'b0, 1'b1, w, b, x, y);
    sb_q.push_back({1'b0, w});
    sb_q.push_back({1'b1, trl});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, sb_q.size(), 0);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_stats = 1'b1;
    @(posedge clk); #1 clr_stats = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int lat;

    vecs[0] = '{x: 12'd640, y: 12'd480, n_data: 5, bits: 5'd13, rmode: 0,
                exp_dims: 32'h001E0280, exp_trl: 32'h0D000006};
    vecs[1] = '{x: 12'd640, y: 12'd480, n_data: 5, bits: 5'd13, rmode: 1,
                exp_dims: 32'h001E0280, exp_trl: 32'h0D000006};
    vecs[2] = '{x: 12'd100, y: 12'd50, n_data: 3, bits: 5'd31, rmode: 0,
                exp_dims: 32'h00032064, exp_trl: 32'h1F000004};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_counters", {frame_count, drop_count, overflow_sticky}, 33'h0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven frames
    foreach (vecs[i]) begin
      rmode = vecs[i].rmode;
      send_frame(vecs[i].x, vecs[i].y, vecs[i].n_data, vecs[i].bits, vecs[i].exp_dims, vecs[i].exp_trl);
      idle_in();
      wait_drain($sformatf("vec%0d_drain", i));
      exp_frames++;
      check($sformatf("vec%0d_frame_count", i), frame_count, exp_frames);
    end
    rmode = 0;

    // One-word frame, also timing the MAGIC beat
    w = $urandom;
    sb_q.push_back({1'b0, MAGIC});
    sb_q.push_back({1'b0, 32'h00008010});
    sb_q.push_back({1'b0, w});
    sb_q.push_back({1'b1, 32'h07000001});
    drive(1'b0, 1'b1, w, 5'd7, 12'd16, 12'd8);
    idle_in();
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_valid && lat < 0) lat = i;
    end
    check("magic_latency_ok", (lat >= 0 && lat <= 3), 1'b1);
    wait_drain("one_word_drain");
    exp_frames++;
    check("one_word_frame_count", frame_count, exp_frames);

    // Back-to-back 3-word frames
    send_frame(12'd1920, 12'd1080, 2, 5'd0, 32'h00438780, 32'h00000003);
    send_frame(12'd4095, 12'd4095, 2, 5'd1, 32'h00FFFFFF, 32'h01000003);
    idle_in();
    wait_drain("b2b_drain");
    exp_frames += 2;
    check("b2b_frame_count", frame_count, exp_frames);

    // Overflow: sink stalled, 20 data words then eof into a 16-entry FIFO
    rmode = 2;
    repeat (3) @(posedge clk);
    sb_q.push_back({1'b0, MAGIC});
    sb_q.push_back({1'b0, 32'h000F0140});
    for (int i = 0; i < 20; i++) begin
      w = $urandom;
      drive(1'b1, 1'b0, w, '0, 12'd320, 12'd240);
      if (i < 16) sb_q.push_back({1'b0, w});
    end
    drive(1'b0, 1'b1, $urandom, 5'd3, 12'd320, 12'd240);
    idle_in();
    repeat (4) @(negedge clk);
    check("ovf_drop_count", drop_count, 16'd4);
    check("ovf_sticky", overflow_sticky, 1'b1);
    check("ovf_busy", busy, 1'b1);
    check("ovf_held_magic", {m_valid, m_data}, {1'b1, MAGIC});
    sb_q.push_back({1'b1, 32'h80000010});
    rmode = 0;
    wait_drain("ovf_drain");
    check("ovf_frame_count", frame_count, exp_frames);
    check("ovf_drop_after", drop_count, 16'd4);

    // Statistics clear
    pulse_clr();
    exp_frames = 0;
    check("clr_counters", {frame_count, drop_count, overflow_sticky}, 33'h0);

    // Data and eof valid together: eof word kept, data word counted as dropped
    begin
      logic [31:0] d0, d1, d2;
      d0 = $urandom; d1 = $urandom; d2 = $urandom;
      sb_q.push_back({1'b0, MAGIC});
      sb_q.push_back({1'b0, 32'h00020040});
      sb_q.push_back({1'b0, d0});
      sb_q.push_back({1'b0, d1});
      sb_q.push_back({1'b0, d2});
      sb_q.push_back({1'b1, 32'h05000003});
      drive(1'b1, 1'b0, d0, '0, 12'd64, 12'd32);
      drive(1'b1, 1'b0, d1, '0, 12'd64, 12'd32);
      drive(1'b1, 1'b1, d2, 5'd5, 12'd64, 12'd32);
      idle_in();
      wait_drain("dual_drain");
      exp_frames++;
      check("dual_drop_count", drop_count, 16'd1);
      check("dual_frame_count", frame_count, exp_frames);
      check("dual_sticky", overflow_sticky, 1'b0);
    end

    // Reset in the middle of the payload
    rmode = 1;
    sb_q.push_back({1'b0, MAGIC});
    sb_q.push_back({1'b0, 32'h000640C8});
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      drive(1'b1, 1'b0, w, '0, 12'd200, 12'd100);
      sb_q.push_back({1'b0, w});
    end
    idle_in();
    repeat (2) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    sb_q.delete();
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_counters", {frame_count, drop_count, overflow_sticky}, 33'h0);
    rmode = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    pulse_clr();
    exp_frames = 0;
    check("post_rst_counters", {frame_count, drop_count, overflow_sticky}, 33'h0);
    send_frame(12'd8, 12'd8, 2, 5'd9, 32'h00008008, 32'h09000003);
    idle_in();
    wait_drain("post_rst_drain");
    exp_frames++;
    check("post_rst_frame_count", frame_count, exp_frames);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_bitstream_framer.md
Name: jpeg_bitstream_framer

Overview:
Frames the raw 32-bit JPEG encoder output into a self-describing stream for the downstream memory writer. The encoder has no backpressure, so the framer buffers words in a FIFO, prepends a 2-word header and appends a 1-word trailer with size and error status. It sits between the encoder output ports and the stream-to-DDR writer, and owns frame accounting and the overflow policy.

Parameters:
DEPTH, 512, FIFO depth in entries; power of two, minimum 16.
MAGIC, 32'h4A504547, header word 0 ("JPEG").

Ports:
clk  in  1  clock
rstn  in  1  reset
enc_pixel_x  in  12  frame width; sampled on the frame's first push
enc_pixel_y  in  12  frame height; sampled on the frame's first push
enc_data  in  32  encoder bitstream word
enc_data_valid  in  1  full word valid
enc_eof_valid  in  1  last (partial) word valid; ends the frame
enc_eof_bits  in  5  valid bits in last word, passed through
m_data  out  32  output beat
m_valid  out  1  beat valid
m_ready  in  1  sink accepts beat
m_last  out  1  trailer beat
busy  out  1  frame in flight (write or read side)
frame_count  out  16  good frames delivered, wrapping
drop_count  out  16  discarded input words, saturating
overflow_sticky  out  1  an overflow has occurred
clr_stats  in  1  synchronous clear of frame_count, drop_count, overflow_sticky

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. Reset empties the FIFO, returns both FSMs to idle, and drives all outputs to 0. A reset mid-frame abandons the frame with no trailer.
- FIFO entry: {sof, eof, err, bits[4:0], x[11:0], y[11:0], data[31:0]}. x and y are meaningful only when sof=1.
- Write side:
  - The first push after reset or after an eof push is tagged sof and carries enc_pixel_x/y.
  - enc_data_valid pushes one entry with eof=0.
  - enc_eof_valid pushes one entry with eof=1 and bits=enc_eof_bits. A 1-word frame is a single entry with sof=eof=1.
  - enc_data_valid and enc_eof_valid in the same cycle: the eof entry is pushed, the data word is discarded, and drop_count increments.
- Overflow:
  - A push while the FIFO is full discards the word, sets overflow_sticky, increments drop_count, and enters DROP mode.
  - In DROP mode all further words of the frame are discarded and counted.
  - On the frame's eof, a terminator entry {eof=1, err=1, data=0} is queued. It is written on the first cycle the FIFO is not full.
  - Until the terminator is written, all input, including a new frame, is discarded and counted.
- Read FSM states: IDLE, HDR0, HDR1, PAY, TRL.
  - IDLE: if the FIFO head has sof=1, go to HDR0 without popping. If the head has sof=0 (orphan), pop and discard it.
  - HDR0: beat = MAGIC. On accept, go to HDR1.
  - HDR1: beat = {8'h00, y[11:0], x[11:0]} from the head entry. On accept, go to PAY.
  - PAY: beat = head.data. Pop on accept and increment wcnt (24-bit).
    - If the popped entry has eof=1 and err=0, latch bits and go to TRL.
    - If the head has err=1, pop it without a beat, latch err, and go to TRL.
    - If the FIFO is empty, m_valid=0 and the FSM stays in PAY.
  - TRL: beat = {err, 2'b00, bits[4:0], wcnt[23:0]} with m_last=1. On accept: clear wcnt and err, increment frame_count if err=0, go to IDLE.
- Output handshake: registered, AXI-stream rules. m_data and m_last are held stable while m_valid && !m_ready, and m_valid is never withdrawn without acceptance. Throughput is 1 beat/cycle in PAY with m_ready=1.
- Latency: with m_ready=1 and the read FSM idle, the MAGIC beat has m_valid=1 no later than 3 cycles after the first push. The reader can drain frame N while the writer fills frame N+1.
- busy = write side mid-frame, or DROP/terminator pending, or read FSM not IDLE, or FIFO not empty.
- Counters:
  - drop_count saturates at 16'hFFFF; frame_count wraps.
  - clr_stats takes priority over same-cycle increments.

Test Plan:
- Frame of 640x480, 5 data words then eof with bits=13, m_ready=1 -> beats MAGIC, 32'h001E0280, 5 payload words, the eof word, trailer 32'h0D000006 with m_last=1; frame_count=1.
- 1-word frame (eof only, bits=7) -> MAGIC, dims, the word, trailer 32'h07000001.
- m_ready toggling 1010 for the whole frame -> identical beat sequence; m_data stable whenever m_valid && !m_ready.
- DEPTH=16, m_ready=0, 20 data words then eof -> 16 entries held, 4 words dropped, drop_count=4, overflow_sticky=1. After m_ready=1: header, 16 payload words, then trailer bit31=1 with wcnt=16; frame_count=0.
- Two back-to-back 3-word frames with m_ready=1 -> two complete framed sequences in order with correct dims each; frame_count=2.
- rstn low mid-PAY, then clr_stats -> m_valid=0, FIFO empty, counters 0. The next frame is framed correctly from MAGIC.
